alu_arbiter: RTL and testbench

//   Shares the single combinational ALU between two requesters (req0 = execute stage, req1 = address/aux unit).

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Requester 0 is the execute stage and requester 1 is the address/aux unit.
// A round-robin grant picks one requester. The accepted operation is
// registered and driven to the ALU. The ALU result is captured into a
// single-entry response register that carries the requester ID. Only one
// operation is in flight at a time, so a new operation can issue at most
// once every 3 cycles.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready                N=0,1 request handshake
//   reqN_a/b/shamt/func             N=0,1 operands and function code
//   alu_i1/i2/shamt/func            registered operation driven to the ALU
//   alu_o                           combinational ALU result
//   rsp_valid/ready/id/data/err     registered response and its handshake
//   busy                            high when the FSM is not in IDLE
//
// Build option
//   ALU_ARB_DIV0_CHK_EN: when defined, a divide (func 4'b1100) with b == 0
//   returns data 0 and sets rsp_err. When undefined, rsp_err is always 0.
//
// State | meaning
// IDLE  | waiting for a request; ready goes to the granted requester
// EXEC  | operation registers drive the ALU; the result is captured at the edge
// RESP  | response is held until the consumer takes it

module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int FUNC_W  = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [FUNC_W-1:0]  req0_func,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [FUNC_W-1:0]  req1_func,
    output logic [WIDTH-1:0]   alu_i1,
    output logic [WIDTH-1:0]   alu_i2,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [FUNC_W-1:0]  alu_func,
    input  logic [WIDTH-1:0]   alu_o,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic [SHAMT_W-1:0]  op_shamt_q, op_shamt_d;
    logic [FUNC_W-1:0]   op_func_q, op_func_d;
    logic                op_id_q, op_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                grant_id;

    // On a tie the requester that was not served last wins.
    // Otherwise the only valid requester wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_shamt_d   = op_shamt_q;
        op_func_d    = op_func_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted. Reset wins at the
                // edge, so a handshake shown during reset would be lost.
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    op_a_d     = grant_id ? req1_a     : req0_a;
                    op_b_d     = grant_id ? req1_b     : req0_b;
                    op_shamt_d = grant_id ? req1_shamt : req0_shamt;
                    op_func_d  = grant_id ? req1_func  : req0_func;
                    op_id_d    = grant_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_data_d  = alu_o;
                rsp_err_d   = 1'b0;
`ifdef ALU_ARB_DIV0_CHK_EN
                if (op_func_q == FUNC_W'(4'b1100) && op_b_q == '0) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_shamt_q   <= '0;
            op_func_q    <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_shamt_q   <= op_shamt_d;
            op_func_q    <= op_func_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_i1    = op_a_q;
    assign alu_i2    = op_b_q;
    assign alu_shamt = op_shamt_q;
    assign alu_func  = op_func_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It models the ALU behind the arbiter and checks
// every cycle against a transaction-level model. Directed scenarios add
// literal expectations on top of the model checks.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_func, req1_func;
    logic [31:0] alu_i1, alu_i2, alu_o;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_func;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FUNC_W(4), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_func(req1_func),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_shamt(alu_shamt), .alu_func(alu_func),
        .alu_o(alu_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Reference ALU: sub is b - a, shifts act on b, divide by zero gives all ones.
    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (f)
            4'b0000: return a + b;
            4'b0001: return b - a;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0110: return b << sh;
            4'b0111: return b >> sh;
            4'b1100: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_o = alu_ref(alu_func, alu_i1, alu_i2, alu_shamt);

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Transaction-level model: one op in flight. Its response appears 2 cycles
    // after acceptance and is held until consumed.
    bit          m_inflight = 0;
    bit          m_last = 1;
    int          m_due = 0;
    bit          m_id = 0;
    logic [31:0] m_data = 0;
    bit          m_err = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [4:0]  m_sh = 0;
    logic [3:0]  m_f = 0;
    bit          ev, e_r0, e_r1;

    typedef struct { bit id; logic [31:0] data; bit err; int acc; int rc; } rec_t;
    rec_t log_q[$];
    int   acc_q[$];
    rec_t r;

    always @(negedge clk) begin
        cyc++;
        if (en) begin
            ev   = m_inflight && (cyc >= m_due);
            e_r0 = !m_inflight && rst_n && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_inflight && rst_n && req1_valid && (!req0_valid || !m_last);
            chk("busy", 32'(busy), 32'(m_inflight));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("alu_i1", alu_i1, m_a);
            chk("alu_i2", alu_i2, m_b);
            chk("alu_shamt", 32'(alu_shamt), 32'(m_sh));
            chk("alu_func", 32'(alu_func), 32'(m_f));

            // Log of what the DUT actually did, used by the directed literal checks.
            if (!rst_n) begin
                acc_q.delete();
            end else begin
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_q.push_back(cyc);
                if (rsp_valid && rsp_ready && acc_q.size() > 0) begin
                    r.id = rsp_id; r.data = rsp_data; r.err = rsp_err;
                    r.acc = acc_q.pop_front(); r.rc = cyc;
                    log_q.push_back(r);
                end
            end

            // Model advance for the coming edge.
            if (!rst_n) begin
                m_inflight = 0; m_last = 1;
                m_a = 0; m_b = 0; m_sh = 0; m_f = 0;
            end else if (!m_inflight && (req0_valid || req1_valid)) begin
                m_id = e_r1;
                m_a  = e_r1 ? req1_a : req0_a;
                m_b  = e_r1 ? req1_b : req0_b;
                m_sh = e_r1 ? req1_shamt : req0_shamt;
                m_f  = e_r1 ? req1_func : req0_func;
                m_data = alu_ref(m_f, m_a, m_b, m_sh);
                m_err  = 0;
`ifdef ALU_ARB_DIV0_CHK_EN
                if (m_f == 4'b1100 && m_b == 0) begin
                    m_data = 0;
                    m_err  = 1;
                end
`endif
                m_inflight = 1;
                m_due = cyc + 2;
            end else if (ev && rsp_ready) begin
                m_inflight = 0;
                m_last = m_id;
            end
        end
    end

    task automatic set_req(input bit n, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] f);
        if (n) begin
            req1_a = a; req1_b = b; req1_shamt = sh; req1_func = f; req1_valid = 1;
        end else begin
            req0_a = a; req0_b = b; req0_shamt = sh; req0_func = f; req0_valid = 1;
        end
    endtask

    task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] f);
        bit got = 0;
        set_req(n, a, b, sh, f);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (n ? req1_ready : req0_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now(n ? "issue_req1" : "issue_req0");
        @(posedge clk); #1;
        if (n) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !req0_valid && !req1_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("drain");
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic chk_log(input int idx, input bit id, input logic [31:0] data, input bit err);
        if (log_q.size() <= idx) begin
            fail_now("log_missing");
        end else begin
            chk("log_id", 32'(log_q[idx].id), 32'(id));
            chk("log_data", log_q[idx].data, data);
            chk("log_err", 32'(log_q[idx].err), 32'(err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n0, n1;
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_shamt = 0; req0_func = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_shamt = 0; req1_func = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; en = 1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_i1", alu_i1, 0);
        chk("rst_ready0", 32'(req0_ready), 0);

        // 1: single requester, add
        base = log_q.size();
        issue(0, 5, 7, 0, 4'b0000);
        drain();
        chk_log(base, 0, 12, 0);
        if (log_q.size() > base) chk("t1_latency", 32'(log_q[base].rc - log_q[base].acc), 2);

        // 2: tie after reset goes to req0, then req1
        do_reset();
        base = log_q.size();
        fork
            issue(0, 3, 10, 0, 4'b0001);
            issue(1, 0, 1, 4, 4'b0110);
        join
        drain();
        chk_log(base, 0, 7, 0);
        chk_log(base + 1, 1, 16, 0);

        // 3: both held valid for 4 ops -> 0,1,0,1 at 3-cycle spacing
        base = log_q.size();
        n0 = 0; n1 = 0;
        set_req(0, 1, 2, 0, 4'b0000);
        set_req(1, 32'hF0, 32'h0F, 0, 4'b0100);
        for (int i = 0; i < 60 && !(n0 == 2 && n1 == 2); i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) n0++;
            if (req1_valid && req1_ready) n1++;
            @(posedge clk); #1;
            if (n0 == 2) req0_valid = 0;
            if (n1 == 2) req1_valid = 0;
        end
        if (!(n0 == 2 && n1 == 2)) fail_now("t3_handshakes");
        req0_valid = 0; req1_valid = 0;
        drain();
        chk_log(base, 0, 3, 0);
        chk_log(base + 1, 1, 32'hFF, 0);
        chk_log(base + 2, 0, 3, 0);
        chk_log(base + 3, 1, 32'hFF, 0);
        for (int k = 1; k < 4; k++)
            if (log_q.size() > base + k)
                chk("t3_spacing", 32'(log_q[base + k].rc - log_q[base + k - 1].rc), 3);

        // 4: response back-pressure for 5 cycles while req1 waits
        base = log_q.size();
        rsp_ready = 0;
        issue(0, 20, 50, 0, 4'b0001);
        set_req(1, 1, 1, 0, 4'b0000);
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) fail_now("t4_rsp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_data", rsp_data, 30);
            chk("t4_id", 32'(rsp_id), 0);
            chk("t4_ready1", 32'(req1_ready), 0);
            chk("t4_busy", 32'(busy), 1);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
        issue(1, 1, 1, 0, 4'b0000);
        drain();
        chk_log(base, 0, 30, 0);
        chk_log(base + 1, 1, 2, 0);

        // 5: reset mid-EXEC discards the op and restores req0 tie priority
        base = log_q.size();
        issue(0, 2, 2, 0, 4'b0000);
        drain();
        issue(1, 9, 9, 0, 4'b0000);
        rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1 chk("t5_no_rsp", 32'(log_q.size()), 32'(base + 1));
        fork
            issue(0, 1, 0, 0, 4'b0000);
            issue(1, 2, 0, 0, 4'b0000);
        join
        drain();
        chk_log(base, 0, 4, 0);
        chk_log(base + 1, 0, 1, 0);
        chk_log(base + 2, 1, 2, 0);

        // 6: divide, with and without a zero divisor
        base = log_q.size();
        issue(0, 100, 0, 0, 4'b1100);
        drain();
        issue(0, 100, 7, 0, 4'b1100);
        drain();
`ifdef ALU_ARB_DIV0_CHK_EN
        chk_log(base, 0, 0, 1);
`else
        chk_log(base, 0, 32'hFFFF_FFFF, 0);
`endif
        chk_log(base + 1, 0, 14, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
